// File: rtl/valid_busy_control_mc.sv
// Multi-channel valid/busy handshake model: each channel holds busy for a programmable
// length, enforces a programmable low gap, and queues a bounded number of early requests.
module valid_busy_control_mc #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned PEND_DEPTH = 2,
    parameter int unsigned PEND_W     = (PEND_DEPTH > 0) ? $clog2(PEND_DEPTH + 1) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     soft_clr,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [CNT_W-1:0]         cfg_busy_len,
    input  logic [CNT_W-1:0]         cfg_gap_len,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH*PEND_W-1:0] pend_cnt
);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    logic [CNT_W-1:0] busy_len_eff;
    assign busy_len_eff = (cfg_busy_len == '0) ? CNT_W'(1) : cfg_busy_len;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] len_q;
        logic [CNT_W-1:0] gap_q;
        logic [PEND_W-1:0] pend_q;
        logic             busy_q;
        logic             done_q;
        logic             ovf_q;

        logic last_busy;
        logic last_gap;
        logic decide;
        logic launch;
        logic pend_full;

        assign last_busy = (state_q == StBusy) && (cnt_q == len_q);
        assign last_gap  = (state_q == StGap) && (cnt_q == gap_q);
        // The launch decision happens at the end of the gap, or at the end of busy when G=0.
        assign decide    = (last_busy && (gap_q == '0)) || last_gap;
        assign launch    = decide && ((pend_q != '0) || valid[g]);
        assign pend_full = (pend_q >= PEND_W'(PEND_DEPTH));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                len_q   <= '0;
                gap_q   <= '0;
                pend_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (soft_clr) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                len_q   <= '0;
                gap_q   <= '0;
                pend_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                ovf_q  <= 1'b0;

                case (state_q)
                    StIdle: begin
                        if (valid[g]) begin
                            state_q <= StBusy;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(1);
                            len_q   <= busy_len_eff;
                            gap_q   <= cfg_gap_len;
                        end
                    end
                    StBusy: begin
                        if (last_busy) begin
                            done_q <= 1'b1;
                            if (gap_q != '0) begin
                                state_q <= StGap;
                                busy_q  <= 1'b0;
                                cnt_q   <= CNT_W'(1);
                            end else if (launch) begin
                                state_q <= StBusy;
                                busy_q  <= 1'b1;
                                cnt_q   <= CNT_W'(1);
                                len_q   <= busy_len_eff;
                                gap_q   <= cfg_gap_len;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                cnt_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StGap: begin
                        if (last_gap) begin
                            if (launch) begin
                                state_q <= StBusy;
                                busy_q  <= 1'b1;
                                cnt_q   <= CNT_W'(1);
                                len_q   <= busy_len_eff;
                                gap_q   <= cfg_gap_len;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                cnt_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                endcase

                // A request seen while idle is consumed by the launch and never queued.
                if (state_q != StIdle) begin
                    if (decide) begin
                        if (launch && !valid[g] && (pend_q != '0)) begin
                            pend_q <= pend_q - PEND_W'(1);
                        end
                    end else if (valid[g]) begin
                        if (!pend_full) begin
                            pend_q <= pend_q + PEND_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
            end
        end

        assign busy[g]                       = busy_q;
        assign done[g]                       = done_q;
        assign overflow[g]                   = ovf_q;
        assign pend_cnt[g*PEND_W +: PEND_W]  = pend_q;
    end

endmodule

// File: tb/tb_valid_busy_control_mc.sv
// Directed scenarios for valid_busy_control_mc; per-cycle expectations go through a scoreboard
// queue that a negedge monitor drains and compares.
module tb_valid_busy_control_mc;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 4;
    localparam int PEND_DEPTH = 2;
    localparam int PEND_W     = 2;
    localparam int MAXC       = 40;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     soft_clr;
    logic [NUM_CH-1:0]        valid;
    logic [CNT_W-1:0]         cfg_busy_len;
    logic [CNT_W-1:0]         cfg_gap_len;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        done;
    logic [NUM_CH-1:0]        overflow;
    logic [NUM_CH*PEND_W-1:0] pend_cnt;

    valid_busy_control_mc #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .PEND_DEPTH(PEND_DEPTH),
        .PEND_W    (PEND_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_clr    (soft_clr),
        .valid       (valid),
        .cfg_busy_len(cfg_busy_len),
        .cfg_gap_len (cfg_gap_len),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .pend_cnt    (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                       scn;
        int                       cyc;
        logic [NUM_CH-1:0]        busy;
        logic [NUM_CH-1:0]        done;
        logic [NUM_CH-1:0]        ovf;
        logic [NUM_CH*PEND_W-1:0] pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   scn_id = 0;

    logic [NUM_CH-1:0]        e_busy[MAXC];
    logic [NUM_CH-1:0]        e_done[MAXC];
    logic [NUM_CH-1:0]        e_ovf[MAXC];
    logic [NUM_CH*PEND_W-1:0] e_pend[MAXC];
    logic [NUM_CH-1:0]        s_vld[MAXC];
    logic [CNT_W-1:0]         s_len[MAXC];
    logic [CNT_W-1:0]         s_gap[MAXC];
    logic                     s_clr[MAXC];

    task automatic chk(input string nm, input int scn, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s scn%0d cyc%0d: got %h want %h", nm, scn, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("busy", e.scn, e.cyc, 32'(busy), 32'(e.busy));
            chk("done", e.scn, e.cyc, 32'(done), 32'(e.done));
            chk("overflow", e.scn, e.cyc, 32'(overflow), 32'(e.ovf));
            chk("pend_cnt", e.scn, e.cyc, 32'(pend_cnt), 32'(e.pend));
        end
    end

    task automatic new_scn(input int l, input int g);
        scn_id++;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = '0;
            e_done[c] = '0;
            e_ovf[c]  = '0;
            e_pend[c] = '0;
            s_vld[c]  = '0;
            s_len[c]  = CNT_W'(l);
            s_gap[c]  = CNT_W'(g);
            s_clr[c]  = 1'b0;
        end
    endtask

    task automatic set_busy(input int ch, input int from, input int to);
        for (int c = from; c <= to; c++) e_busy[c][ch] = 1'b1;
    endtask

    task automatic set_pend(input int ch, input int from, input int to, input int val);
        for (int c = from; c <= to; c++) e_pend[c][ch*PEND_W +: PEND_W] = PEND_W'(val);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            valid        = s_vld[c];
            cfg_busy_len = s_len[c];
            cfg_gap_len  = s_gap[c];
            soft_clr     = s_clr[c];
            e.scn  = scn_id;
            e.cyc  = c;
            e.busy = e_busy[c];
            e.done = e_done[c];
            e.ovf  = e_ovf[c];
            e.pend = e_pend[c];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid    = '0;
        soft_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        soft_clr     = 1'b0;
        valid        = '0;
        cfg_busy_len = '0;
        cfg_gap_len  = '0;
        #12;
        chk("reset_busy", 0, 0, 32'(busy), 32'h0);
        chk("reset_done", 0, 0, 32'(done), 32'h0);
        chk("reset_ovf", 0, 0, 32'(overflow), 32'h0);
        chk("reset_pend", 0, 0, 32'(pend_cnt), 32'h0);
        #8;
        rst_n = 1'b1;

        // Single launch: L=5, G=6, ch0 valid at cycle 10.
        new_scn(5, 6);
        s_vld[10][0] = 1'b1;
        set_busy(0, 11, 15);
        e_done[16][0] = 1'b1;
        run(24);

        // Queueing: L=3, G=2, ch1 valid at 0, 2, 3.
        new_scn(3, 2);
        s_vld[0][1] = 1'b1;
        s_vld[2][1] = 1'b1;
        s_vld[3][1] = 1'b1;
        set_busy(1, 1, 3);
        set_busy(1, 6, 8);
        set_busy(1, 11, 13);
        e_done[4][1]  = 1'b1;
        e_done[9][1]  = 1'b1;
        e_done[14][1] = 1'b1;
        set_pend(1, 3, 3, 1);
        set_pend(1, 4, 5, 2);
        set_pend(1, 6, 10, 1);
        run(18);

        // Overflow: L=8, G=0, ch2 valid at 0..3; fourth request dropped.
        new_scn(8, 0);
        for (int c = 0; c < 4; c++) s_vld[c][2] = 1'b1;
        set_busy(2, 1, 24);
        e_done[9][2]  = 1'b1;
        e_done[17][2] = 1'b1;
        e_done[25][2] = 1'b1;
        e_ovf[4][2]   = 1'b1;
        set_pend(2, 2, 2, 1);
        set_pend(2, 3, 8, 2);
        set_pend(2, 9, 16, 1);
        run(28);

        // Zero length and zero gap: valid held 3 cycles on ch3.
        new_scn(0, 0);
        for (int c = 0; c < 3; c++) s_vld[c][3] = 1'b1;
        set_busy(3, 1, 3);
        e_done[2][3] = 1'b1;
        e_done[3][3] = 1'b1;
        e_done[4][3] = 1'b1;
        run(6);

        // Config hold: L=4 at launch, cfg goes to 9 mid-window; queued relaunch uses 9.
        // ch3 launches independently at cycle 6 with the shared cfg of 9.
        new_scn(4, 0);
        for (int c = 2; c < MAXC; c++) s_len[c] = CNT_W'(9);
        s_vld[0][0] = 1'b1;
        s_vld[2][0] = 1'b1;
        s_vld[6][3] = 1'b1;
        set_busy(0, 1, 4);
        set_busy(0, 5, 13);
        e_done[5][0]  = 1'b1;
        e_done[14][0] = 1'b1;
        set_pend(0, 3, 4, 1);
        set_busy(3, 7, 15);
        e_done[16][3] = 1'b1;
        run(18);

        // Maximum lengths: L=15, G=15 on ch1.
        new_scn(15, 15);
        s_vld[0][1] = 1'b1;
        set_busy(1, 1, 15);
        e_done[16][1] = 1'b1;
        run(33);

        // Soft clear mid-busy with pend=2; same-cycle valid on ch0/ch2 is discarded.
        new_scn(8, 0);
        for (int c = 0; c < 3; c++) s_vld[c][2] = 1'b1;
        s_vld[5] = 4'b0101;
        s_clr[5] = 1'b1;
        set_busy(2, 1, 5);
        set_pend(2, 2, 2, 1);
        set_pend(2, 3, 5, 2);
        run(10);

        // Asynchronous reset between edges while ch2 is busy with pend=2.
        new_scn(8, 0);
        for (int c = 0; c < 3; c++) s_vld[c][2] = 1'b1;
        set_busy(2, 1, 4);
        set_pend(2, 2, 2, 1);
        set_pend(2, 3, 4, 2);
        run(5);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", scn_id, 6, 32'(busy), 32'h4);
        chk("pre_rst_pend", scn_id, 6, 32'(pend_cnt), 32'h20);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", scn_id, 6, 32'(busy), 32'h0);
        chk("async_rst_pend", scn_id, 6, 32'(pend_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset: L=2, G=0 on ch0.
        new_scn(2, 0);
        s_vld[0][0] = 1'b1;
        set_busy(0, 1, 2);
        e_done[3][0] = 1'b1;
        run(5);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
